mmio_read_ctrl: RTL and testbench

Load-path controller for the memory-mapped peripheral window, placed in the MEM stage in front of the load write-back mux. DMEM loads pass through combinationally with no added latency. Loads to a peripheral register become a registered request/acknowledge transaction to the slow peripheral bus. The pipeline is stalled until the peripheral answers or, optionally, a timeout fires.

---
 rtl/mmio_read_ctrl_if.sv | 10 +
 rtl/mmio_read_ctrl.sv | 150 +++++++++++++++
 tb/tb_mmio_read_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_read_ctrl_if.sv
// Peripheral read bus between mmio_read_ctrl (master) and the slow peripheral block (slave).
interface mmio_read_ctrl_if;
  logic        per_req;
  logic [2:0]  per_sel;
  logic        per_ack;
  logic [31:0] per_rdata;

  modport master (output per_req, output per_sel, input per_ack, input per_rdata);
  modport slave  (input per_req, input per_sel, output per_ack, output per_rdata);
endinterface

// File: rtl/mmio_read_ctrl.sv
// MEM-stage load controller: DMEM loads pass through, peripheral-window loads stall the pipe
// for a req/ack transaction. Define MMIO_TIMEOUT_EN to add the REQ timeout and sticky err.
module mmio_read_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic [31:0]             addr,
  input  logic [31:0]             dmem_rdata,
  output logic                    stall,
  output logic [31:0]             rdata,
  output logic                    rdata_valid,
  output logic                    err,
  input  logic                    err_clr,
  mmio_read_ctrl_if.master        per
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic        per_req_q, per_req_d;
  logic [2:0]  per_sel_q, per_sel_d;
  logic [31:0] hold_q, hold_d;
  logic        hit;
  logic [2:0]  hit_sel;
  logic        timeout;

  // Only the low 12 bits select a peripheral register.
  logic [19:0] unused_addr;
  assign unused_addr = addr[31:12];

  always_comb begin
    hit     = 1'b0;
    hit_sel = 3'd0;
    if (addr[11]) begin
      unique case (addr[11:0])
        12'h808: begin hit = 1'b1; hit_sel = 3'd0; end
        12'h80C: begin hit = 1'b1; hit_sel = 3'd1; end
        12'h814: begin hit = 1'b1; hit_sel = 3'd2; end
        12'h820: begin hit = 1'b1; hit_sel = 3'd3; end
        12'h824: begin hit = 1'b1; hit_sel = 3'd4; end
        12'h828: begin hit = 1'b1; hit_sel = 3'd5; end
        12'h834: begin hit = 1'b1; hit_sel = 3'd6; end
        default: begin hit = 1'b0; hit_sel = 3'd0; end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    per_req_d = per_req_q;
    per_sel_d = per_sel_q;
    hold_d    = hold_q;
    unique case (state_q)
      StIdle: begin
        if (rd_en && hit) begin
          per_sel_d = hit_sel;
          per_req_d = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (per.per_ack) begin
          hold_d    = per.per_rdata;
          per_req_d = 1'b0;
          state_d   = StDone;
        end else if (timeout) begin
          hold_d    = 32'hDEAD_BEEF;
          per_req_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        state_d   = StIdle;
        per_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      per_req_q <= 1'b0;
      per_sel_q <= 3'd0;
      hold_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      per_req_q <= per_req_d;
      per_sel_q <= per_sel_d;
      hold_q    <= hold_d;
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Count value k-1 during the k-th REQ cycle, so the abort lands on REQ cycle TIMEOUT_CYCLES.
  assign timeout = (state_q == StReq) && !per.per_ack &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != StReq) begin
      cnt_d = '0;
    end else if (!per.per_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q;
    if (timeout) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic        unused_err_clr;
  logic [31:0] unused_timeout_cycles;
  assign unused_err_clr        = err_clr;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout               = 1'b0;
  assign err                   = 1'b0;
`endif

  always_comb begin
    stall       = ((state_q == StIdle) && rd_en && hit) || (state_q == StReq);
    rdata       = (state_q == StDone) ? hold_q : dmem_rdata;
    rdata_valid = rd_en && !stall;
  end

  assign per.per_req = per_req_q;
  assign per.per_sel = per_sel_q;

endmodule

// File: tb/tb_mmio_read_ctrl.sv
// Randomized self-checking bench for mmio_read_ctrl against a transaction-level load model.
module tb_mmio_read_ctrl;
`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned To = 8;
`else
  localparam int unsigned To = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        stall, rdata_valid, err;
  logic [31:0] rdata;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic        exp_err = 1'b0;

  logic [11:0] offs [7] = '{12'h808, 12'h80C, 12'h814, 12'h820, 12'h824, 12'h828, 12'h834};

  mmio_read_ctrl_if bus ();

  mmio_read_ctrl #(.TIMEOUT_CYCLES(To)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en       (rd_en),
    .addr        (addr),
    .dmem_rdata  (dmem_rdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .err_clr     (err_clr),
    .per         (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int exp_target(input logic [31:0] a);
    for (int i = 0; i < 7; i++) if (a[11:0] == offs[i]) return i;
    return -1;
  endfunction

  // Inputs change 1 after the edge, outputs are sampled 4 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [31:0] a);
    step();
    rd_en = 1'b0; addr = a; dmem_rdata = $urandom; bus.per_ack = 1'($urandom);
    #3;
    check_eq("idle_stall", stall, 1'b0);
    check_eq("idle_valid", rdata_valid, 1'b0);
    check_eq("idle_req", bus.per_req, 1'b0);
  endtask

  task automatic dmem_load(input logic [31:0] a, input logic [31:0] d);
    step();
    rd_en = 1'b1; addr = a; dmem_rdata = d; bus.per_ack = 1'($urandom);
    bus.per_rdata = $urandom;
    #3;
    check_eq("dmem_stall", stall, 1'b0);
    check_eq("dmem_valid", rdata_valid, 1'b1);
    check_eq("dmem_rdata", rdata, d);
    check_eq("dmem_req", bus.per_req, 1'b0);
  endtask

  // k = REQ cycle carrying the ack (1 = first); k = 0 means no ack, i.e. timeout.
  task automatic periph_load(input logic [31:0] a, input int k, input logic [31:0] d,
                             input logic clr);
    int          tgt;
    int          n_req;
    logic [31:0] exp_data;
    tgt      = exp_target(a);
    n_req    = (k > 0) ? k : int'(To);
    exp_data = (k > 0) ? d : 32'hDEAD_BEEF;
    step();
    rd_en = 1'b1; addr = a; dmem_rdata = $urandom; bus.per_ack = 1'b0; err_clr = clr;
    #3;
    check_eq("dec_stall", stall, 1'b1);
    check_eq("dec_valid", rdata_valid, 1'b0);
    for (int j = 1; j <= n_req; j++) begin
      step();
      bus.per_ack   = (j == k);
      bus.per_rdata = (j == k) ? d : $urandom;
      dmem_rdata    = $urandom;
      #3;
      check_eq("req_req", bus.per_req, 1'b1);
      check_eq("req_stall", stall, 1'b1);
      check_eq("req_sel", bus.per_sel, 32'(tgt));
    end
    step();
    bus.per_ack = 1'b0; err_clr = 1'b0; dmem_rdata = $urandom;
`ifdef MMIO_TIMEOUT_EN
    if (k == 0) exp_err = 1'b1;
`endif
    #3;
    check_eq("done_stall", stall, 1'b0);
    check_eq("done_valid", rdata_valid, 1'b1);
    check_eq("done_rdata", rdata, exp_data);
    check_eq("done_req", bus.per_req, 1'b0);
    check_eq("done_err", err, exp_err);
  endtask

  task automatic clear_err();
    step();
    rd_en = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_err = 1'b0;
    #3;
    check_eq("err_clr", err, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bus.per_ack = 1'b0;
    bus.per_rdata = 32'd0;
    #1;
    check_eq("rst_req", bus.per_req, 1'b0);
    check_eq("rst_sel", bus.per_sel, 32'd0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_valid", rdata_valid, 1'b0);
    check_eq("rst_err", err, 1'b0);
    #11 rst_n = 1'b1;

    idle_cycle(32'h0000_0808);
    dmem_load(32'h0000_0040, 32'h1234_5678);
    periph_load(32'h0000_0808, 1, 32'hCAFE_0001, 1'b0);
    periph_load(32'h0000_0828, 5, 32'h0000_00A5, 1'b0);
    dmem_load(32'h0000_0830, 32'h0000_0055);
    periph_load(32'h0000_0834, 2, 32'h0BAD_F00D, 1'b0);
    periph_load(32'h0000_080C, 1, 32'h1111_2222, 1'b0);

`ifdef MMIO_TIMEOUT_EN
    periph_load(32'h0000_0814, 0, 32'd0, 1'b0);
    clear_err();
    periph_load(32'h0000_0814, int'(To), 32'h7777_0008, 1'b0);
    periph_load(32'h0000_0820, 0, 32'd0, 1'b1);
    clear_err();
`endif

    // Reset during REQ with the pipeline flushed at the same time.
    step();
    rd_en = 1'b1; addr = 32'h0000_0820; bus.per_ack = 1'b0;
    step();
    #3;
    check_eq("pre_rst_req", bus.per_req, 1'b1);
    #1;
    rst_n = 1'b0; rd_en = 1'b0;
    #1;
    check_eq("async_rst_req", bus.per_req, 1'b0);
    check_eq("async_rst_stall", stall, 1'b0);
    #2 rst_n = 1'b1;
    exp_err = 1'b0;
    step();
    bus.per_ack = 1'b1; bus.per_rdata = 32'hFFFF_0000;
    rd_en = 1'b1; addr = 32'h0000_0100; dmem_rdata = 32'h0000_ABCD;
    #3;
    check_eq("post_rst_stall", stall, 1'b0);
    check_eq("post_rst_rdata", rdata, 32'h0000_ABCD);
    check_eq("post_rst_valid", rdata_valid, 1'b1);
    step();
    bus.per_ack = 1'b0; rd_en = 1'b0;
    #3;
    check_eq("post_rst_req", bus.per_req, 1'b0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 3);
      a = $urandom;
      if (r == 1) a[11:0] = offs[$urandom_range(0, 6)];
      if (r == 2) a[11] = 1'b1;
      if (r == 3) idle_cycle(a);
      else if (exp_target(a) >= 0) periph_load(a, $urandom_range(1, 6), $urandom, 1'b0);
      else dmem_load(a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
